multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle control unit for the RISC-V core; successor to the single-cycle opcode decoder.
//  Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK per instruction.
//  Stalls on a memory-ready handshake, resolves branches and JAL, and traps on illegal opcodes.
//  Sits between the instruction register opcode field and the datapath mux, enable and ALU controls.
// PARAMETERS
//  ALU_OP_W      3     width of ALU_Op_o; values below zero-extended to this width (min 3)
//  BRANCH_EN     1     1: B_Type (7'h63) executed; 0: B_Type treated as illegal
//  JAL_EN        1     1: J_Type_JAL (7'h6F) executed; 0: treated as illegal
// PORTS
//  clk           in   1         rising-edge clock
//  reset         in   1         asynchronous, active-high; forces state FETCH
//  OP_i          in   7         opcode from instruction register (sampled in DECODE)
//  Zero_i        in   1         ALU zero flag (used in BRANCH)
//  Mem_Ready_i   in   1         memory completes access this cycle
//  PC_Write_o    out  1         PC register load enable
//  IR_Write_o    out  1         instruction register load enable
//  IorD_o        out  1         0: address = PC, 1: address = ALUOut
//  Mem_Read_o    out  1         memory read request
//  Mem_Write_o   out  1         memory write request
//  Mem_to_Reg_o  out  1         writeback source: 1 = MDR, 0 = ALUOut
//  Reg_Write_o   out  1         register file write enable
//  ALU_Src_A_o   out  2         00 PC, 01 old PC, 10 rs1, 11 zero
//  ALU_Src_B_o   out  2         00 rs2, 01 const 4, 10 immediate
//  PC_Src_o      out  1         0: ALU result, 1: ALUOut
//  ALU_Op_o      out  ALU_OP_W  000 R, 001 I-logic, 010 LUI, 011 SW, 100 LW, 101 BR-compare, 110 ADD
//  Retire_o      out  1         one-cycle pulse in each instruction's final cycle
//  Illegal_o     out  1         high while in TRAP
// BEHAVIOUR
//  Moore machine: all outputs are decoded from state only, except the Mem_Ready_i/Zero_i gating noted.
//  Any output not listed for a state is 0.
//  Reset: state = FETCH. Outputs = FETCH row with Mem_Ready_i=0, i.e.
//    Mem_Read_o=1, ALU_Src_B_o=01, ALU_Op_o=110; all others 0.
//  FETCH: IorD=0, Mem_Read=1, SrcA=00, SrcB=01, Op=110.
//    IR_Write=PC_Write=Mem_Ready_i. Stay in FETCH until Mem_Ready_i=1, then go to DECODE.
//  DECODE: SrcA=01, SrcB=10, Op=110 (branch/JAL target -> ALUOut). Next state by OP_i:
//    7'h33 EXEC_R | 7'h13 EXEC_I | 7'h37 LUI | 7'h03,7'h23 MEM_ADDR
//    7'h63 BRANCH (if BRANCH_EN) | 7'h6F JAL (if JAL_EN) | otherwise TRAP.
//  EXEC_R: SrcA=10, SrcB=00, Op=000 -> ALU_WB.  EXEC_I: SrcA=10, SrcB=10, Op=001 -> ALU_WB.
//  LUI: SrcA=11, SrcB=10, Op=010 -> ALU_WB.
//  ALU_WB: Reg_Write=1, Mem_to_Reg=0, Retire=1 -> FETCH.
//  MEM_ADDR: SrcA=10, SrcB=10, Op=100 (LW) or 011 (SW), selected by the opcode latched in DECODE.
//    Next state MEM_RD (LW) or MEM_WR (SW).
//  MEM_RD: IorD=1, Mem_Read=1. Hold until Mem_Ready_i, then MEM_WB.
//  MEM_WB: Reg_Write=1, Mem_to_Reg=1, Retire=1 -> FETCH.
//  MEM_WR: IorD=1, Mem_Write=1, Retire=Mem_Ready_i. Hold until Mem_Ready_i, then FETCH.
//  BRANCH: SrcA=10, SrcB=00, Op=101, PC_Src=1, PC_Write=Zero_i, Retire=1 -> FETCH.
//  JAL: PC_Src=1, PC_Write=1, Reg_Write=1, Mem_to_Reg=0, Retire=1 -> FETCH.
//    Datapath supplies PC+4 on the writeback path.
//  TRAP: Illegal_o=1, all enables 0. Sticky until reset.
//  Opcode: latched into an internal 7-bit register in DECODE; later states use the latched copy.
//    OP_i changes after DECODE have no effect.
//  Mem_Ready_i: ignored outside FETCH, MEM_RD and MEM_WR.
//  Stall: a stall of any length holds every output stable, with no repeated PC_Write or Retire.
//  Latency: R/I/LUI 4 cycles, LW 5, SW 4, BRANCH/JAL 3 (zero wait states).
//  Reset mid-instruction: immediate return to FETCH; no partial write is completed after reset.
//  State register: encoding is implementation-defined; unreachable encodings recover to FETCH.
// TESTING
//  1. Reset mid-MEM_WR -> next cycle FETCH, Mem_Write_o=0, Mem_Read_o=1.
//  2. OP=7'h33, Mem_Ready_i=1 always -> FETCH,DECODE,EXEC_R,ALU_WB.
//     Reg_Write_o=1 and Retire_o=1 only in cycle 4; ALU_Op_o=000 in cycle 3.
//  3. OP=7'h03, Mem_Ready_i low 3 cycles in MEM_RD -> Mem_Read_o=1, IorD_o=1 held 4 cycles.
//     Then MEM_WB asserts Mem_to_Reg_o=1, Reg_Write_o=1, Retire_o=1 once.
//  4. OP=7'h63 with Zero_i=1 -> PC_Write_o=1, PC_Src_o=1 in cycle 3.
//     With Zero_i=0 -> PC_Write_o=0; both cases Retire_o=1.
//  5. OP=7'h7F -> TRAP after DECODE; Illegal_o=1 for 20+ cycles, all enables 0 until reset.
//  6. BRANCH_EN=0, OP=7'h63 -> TRAP.
//     FETCH with Mem_Ready_i=0 for 5 cycles -> IR_Write_o/PC_Write_o stay 0 until ready.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle RISC-V control sequencer
// Moore FSM driving datapath enables and mux selects; stalls on memory, traps on illegal opcodes.
module multicycle_control_fsm #(
  parameter int ALU_OP_W  = 3,
  parameter bit BRANCH_EN = 1'b1,
  parameter bit JAL_EN    = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          OP_i,
  input  logic                Zero_i,
  input  logic                Mem_Ready_i,
  output logic                PC_Write_o,
  output logic                IR_Write_o,
  output logic                IorD_o,
  output logic                Mem_Read_o,
  output logic                Mem_Write_o,
  output logic                Mem_to_Reg_o,
  output logic                Reg_Write_o,
  output logic [1:0]          ALU_Src_A_o,
  output logic [1:0]          ALU_Src_B_o,
  output logic                PC_Src_o,
  output logic [ALU_OP_W-1:0] ALU_Op_o,
  output logic                Retire_o,
  output logic                Illegal_o
);

  localparam logic [6:0] OPC_R      = 7'h33;
  localparam logic [6:0] OPC_I      = 7'h13;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLD_PC = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCA_ZERO   = 2'b11;

  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;

  localparam logic [2:0] ALUOP_R     = 3'b000;
  localparam logic [2:0] ALUOP_I     = 3'b001;
  localparam logic [2:0] ALUOP_LUI   = 3'b010;
  localparam logic [2:0] ALUOP_SW    = 3'b011;
  localparam logic [2:0] ALUOP_LW    = 3'b100;
  localparam logic [2:0] ALUOP_BR    = 3'b101;
  localparam logic [2:0] ALUOP_ADD   = 3'b110;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_LUI      = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [6:0] r_opcode;
  logic [2:0] w_alu_op;
  logic       w_is_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Later states steer from this copy, so OP_i may change freely after DECODE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_opcode <= 7'h00;
    end else if (r_state == S_DECODE) begin
      r_opcode <= OP_i;
    end
  end

  assign w_is_load = (r_opcode == OPC_LOAD);

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = Mem_Ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (OP_i)
          OPC_R:                w_next = S_EXEC_R;
          OPC_I:                w_next = S_EXEC_I;
          OPC_LUI:              w_next = S_LUI;
          OPC_LOAD, OPC_STORE:  w_next = S_MEM_ADDR;
          OPC_BRANCH:           w_next = BRANCH_EN ? S_BRANCH : S_TRAP;
          OPC_JAL:              w_next = JAL_EN ? S_JAL : S_TRAP;
          default:              w_next = S_TRAP;
        endcase
      end
      S_EXEC_R:   w_next = S_ALU_WB;
      S_EXEC_I:   w_next = S_ALU_WB;
      S_LUI:      w_next = S_ALU_WB;
      S_ALU_WB:   w_next = S_FETCH;
      S_MEM_ADDR: w_next = w_is_load ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next = Mem_Ready_i ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   w_next = Mem_Ready_i ? S_FETCH : S_MEM_WR;
      S_BRANCH:   w_next = S_FETCH;
      S_JAL:      w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    PC_Write_o   = 1'b0;
    IR_Write_o   = 1'b0;
    IorD_o       = 1'b0;
    Mem_Read_o   = 1'b0;
    Mem_Write_o  = 1'b0;
    Mem_to_Reg_o = 1'b0;
    Reg_Write_o  = 1'b0;
    ALU_Src_A_o  = SRCA_PC;
    ALU_Src_B_o  = SRCB_RS2;
    PC_Src_o     = 1'b0;
    w_alu_op     = ALUOP_R;
    Retire_o     = 1'b0;
    Illegal_o    = 1'b0;
    case (r_state)
      S_FETCH: begin
        Mem_Read_o  = 1'b1;
        ALU_Src_A_o = SRCA_PC;
        ALU_Src_B_o = SRCB_FOUR;
        w_alu_op    = ALUOP_ADD;
        IR_Write_o  = Mem_Ready_i;
        PC_Write_o  = Mem_Ready_i;
      end
      // Precompute the branch/JAL target into ALUOut while the opcode is decoded.
      S_DECODE: begin
        ALU_Src_A_o = SRCA_OLD_PC;
        ALU_Src_B_o = SRCB_IMM;
        w_alu_op    = ALUOP_ADD;
      end
      S_EXEC_R: begin
        ALU_Src_A_o = SRCA_RS1;
        ALU_Src_B_o = SRCB_RS2;
        w_alu_op    = ALUOP_R;
      end
      S_EXEC_I: begin
        ALU_Src_A_o = SRCA_RS1;
        ALU_Src_B_o = SRCB_IMM;
        w_alu_op    = ALUOP_I;
      end
      S_LUI: begin
        ALU_Src_A_o = SRCA_ZERO;
        ALU_Src_B_o = SRCB_IMM;
        w_alu_op    = ALUOP_LUI;
      end
      S_ALU_WB: begin
        Reg_Write_o = 1'b1;
        Retire_o    = 1'b1;
      end
      S_MEM_ADDR: begin
        ALU_Src_A_o = SRCA_RS1;
        ALU_Src_B_o = SRCB_IMM;
        w_alu_op    = w_is_load ? ALUOP_LW : ALUOP_SW;
      end
      S_MEM_RD: begin
        IorD_o     = 1'b1;
        Mem_Read_o = 1'b1;
      end
      S_MEM_WB: begin
        Reg_Write_o  = 1'b1;
        Mem_to_Reg_o = 1'b1;
        Retire_o     = 1'b1;
      end
      S_MEM_WR: begin
        IorD_o      = 1'b1;
        Mem_Write_o = 1'b1;
        Retire_o    = Mem_Ready_i;
      end
      S_BRANCH: begin
        ALU_Src_A_o = SRCA_RS1;
        ALU_Src_B_o = SRCB_RS2;
        w_alu_op    = ALUOP_BR;
        PC_Src_o    = 1'b1;
        PC_Write_o  = Zero_i;
        Retire_o    = 1'b1;
      end
      S_JAL: begin
        PC_Src_o    = 1'b1;
        PC_Write_o  = 1'b1;
        Reg_Write_o = 1'b1;
        Retire_o    = 1'b1;
      end
      S_TRAP: begin
        Illegal_o = 1'b1;
      end
      default: begin
        Illegal_o = 1'b0;
      end
    endcase
  end

  assign ALU_Op_o = ALU_OP_W'(w_alu_op);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - scoreboard bench for multicycle_control_fsm
// Driver expands each instruction into expected per-cycle output rows; a monitor pops and compares.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] OP_i;
  logic       Zero_i;
  logic       Mem_Ready_i;
  logic       PC_Write_o, IR_Write_o, IorD_o, Mem_Read_o, Mem_Write_o;
  logic       Mem_to_Reg_o, Reg_Write_o, PC_Src_o, Retire_o, Illegal_o;
  logic [1:0] ALU_Src_A_o, ALU_Src_B_o;
  logic [2:0] ALU_Op_o;

  logic       b_reset;
  logic [6:0] b_op;
  logic       b_ready;
  logic       b_pcw, b_irw, b_iord, b_mrd, b_mwr, b_m2r, b_rw, b_pcs, b_ret, b_ill;
  logic [1:0] b_srca, b_srcb;
  logic [2:0] b_aluop;

  int         errors = 0;
  int         checks = 0;
  int         cyc_n  = 0;
  logic       b_done = 1'b0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  multicycle_control_fsm #(.ALU_OP_W(3), .BRANCH_EN(1'b1), .JAL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .OP_i(OP_i), .Zero_i(Zero_i), .Mem_Ready_i(Mem_Ready_i),
    .PC_Write_o(PC_Write_o), .IR_Write_o(IR_Write_o), .IorD_o(IorD_o),
    .Mem_Read_o(Mem_Read_o), .Mem_Write_o(Mem_Write_o), .Mem_to_Reg_o(Mem_to_Reg_o),
    .Reg_Write_o(Reg_Write_o), .ALU_Src_A_o(ALU_Src_A_o), .ALU_Src_B_o(ALU_Src_B_o),
    .PC_Src_o(PC_Src_o), .ALU_Op_o(ALU_Op_o), .Retire_o(Retire_o), .Illegal_o(Illegal_o)
  );

  multicycle_control_fsm #(.ALU_OP_W(3), .BRANCH_EN(1'b0), .JAL_EN(1'b0)) dut_nobr (
    .clk(clk), .reset(b_reset), .OP_i(b_op), .Zero_i(1'b1), .Mem_Ready_i(b_ready),
    .PC_Write_o(b_pcw), .IR_Write_o(b_irw), .IorD_o(b_iord),
    .Mem_Read_o(b_mrd), .Mem_Write_o(b_mwr), .Mem_to_Reg_o(b_m2r),
    .Reg_Write_o(b_rw), .ALU_Src_A_o(b_srca), .ALU_Src_B_o(b_srcb),
    .PC_Src_o(b_pcs), .ALU_Op_o(b_aluop), .Retire_o(b_ret), .Illegal_o(b_ill)
  );

  function automatic logic [16:0] row(input logic pcw, input logic irw, input logic iord,
                                      input logic mrd, input logic mwr, input logic m2r,
                                      input logic rw, input logic [1:0] a, input logic [1:0] b,
                                      input logic pcs, input logic [2:0] op, input logic ret,
                                      input logic ill);
    return {pcw, irw, iord, mrd, mwr, m2r, rw, a, b, pcs, op, ret, ill};
  endfunction

  function automatic logic [16:0] fetch_row(input logic rdy);
    return row(rdy, rdy, 0, 1, 0, 0, 0, 2'b00, 2'b01, 0, 3'b110, 0, 0);
  endfunction
  function automatic logic [16:0] decode_row();
    return row(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0, 3'b110, 0, 0);
  endfunction
  function automatic logic [16:0] trap_row();
    return row(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b000, 0, 1);
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h63, 7'h6F};
  endfunction

  wire [16:0] act = {PC_Write_o, IR_Write_o, IorD_o, Mem_Read_o, Mem_Write_o, Mem_to_Reg_o,
                     Reg_Write_o, ALU_Src_A_o, ALU_Src_B_o, PC_Src_o, ALU_Op_o, Retire_o, Illegal_o};
  wire [16:0] b_act = {b_pcw, b_irw, b_iord, b_mrd, b_mwr, b_m2r, b_rw, b_srca, b_srcb,
                       b_pcs, b_aluop, b_ret, b_ill};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [16:0] e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs cycle=%0d got=%05h expected=%05h", cyc_n, act, e);
      end
    end
  end

  task automatic cyc(input logic rdy, input logic z, input logic [6:0] op,
                     input logic rst, input logic [16:0] e);
    @(posedge clk);
    #1;
    Mem_Ready_i = rdy;
    Zero_i      = z;
    OP_i        = op;
    reset       = rst;
    exp_q.push_back(e);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic logic [6:0] ro();
    return 7'($urandom_range(0, 127));
  endfunction

  // Expand one instruction: fw fetch waits, mw memory waits, optional reset inside a store.
  task automatic issue(input logic [6:0] op, input logic z, input int fw, input int mw,
                       input logic abort, input int trap_len);
    for (int i = 0; i < fw; i++) cyc(0, rb(), ro(), 0, fetch_row(0));
    cyc(1, rb(), ro(), 0, fetch_row(1));
    cyc(rb(), rb(), op, 0, decode_row());
    case (op)
      7'h33: begin
        cyc(rb(), rb(), ro(), 0, row(0,0,0,0,0,0,0, 2'b10, 2'b00, 0, 3'b000, 0, 0));
        cyc(rb(), rb(), ro(), 0, row(0,0,0,0,0,0,1, 2'b00, 2'b00, 0, 3'b000, 1, 0));
      end
      7'h13: begin
        cyc(rb(), rb(), ro(), 0, row(0,0,0,0,0,0,0, 2'b10, 2'b10, 0, 3'b001, 0, 0));
        cyc(rb(), rb(), ro(), 0, row(0,0,0,0,0,0,1, 2'b00, 2'b00, 0, 3'b000, 1, 0));
      end
      7'h37: begin
        cyc(rb(), rb(), ro(), 0, row(0,0,0,0,0,0,0, 2'b11, 2'b10, 0, 3'b010, 0, 0));
        cyc(rb(), rb(), ro(), 0, row(0,0,0,0,0,0,1, 2'b00, 2'b00, 0, 3'b000, 1, 0));
      end
      7'h03: begin
        cyc(rb(), rb(), ro(), 0, row(0,0,0,0,0,0,0, 2'b10, 2'b10, 0, 3'b100, 0, 0));
        for (int i = 0; i < mw; i++)
          cyc(0, rb(), ro(), 0, row(0,0,1,1,0,0,0, 2'b00, 2'b00, 0, 3'b000, 0, 0));
        cyc(1, rb(), ro(), 0, row(0,0,1,1,0,0,0, 2'b00, 2'b00, 0, 3'b000, 0, 0));
        cyc(rb(), rb(), ro(), 0, row(0,0,0,0,0,1,1, 2'b00, 2'b00, 0, 3'b000, 1, 0));
      end
      7'h23: begin
        cyc(rb(), rb(), ro(), 0, row(0,0,0,0,0,0,0, 2'b10, 2'b10, 0, 3'b011, 0, 0));
        for (int i = 0; i < mw; i++)
          cyc(0, rb(), ro(), 0, row(0,0,1,0,1,0,0, 2'b00, 2'b00, 0, 3'b000, 0, 0));
        if (abort) cyc(0, rb(), ro(), 1, fetch_row(0));
        else cyc(1, rb(), ro(), 0, row(0,0,1,0,1,0,0, 2'b00, 2'b00, 0, 3'b000, 1, 0));
      end
      7'h63: cyc(rb(), z, ro(), 0, row(z,0,0,0,0,0,0, 2'b10, 2'b00, 1, 3'b101, 1, 0));
      7'h6F: cyc(rb(), rb(), ro(), 0, row(1,0,0,0,0,0,1, 2'b00, 2'b00, 1, 3'b000, 1, 0));
      default: begin
        for (int i = 0; i < trap_len; i++) cyc(rb(), rb(), ro(), 0, trap_row());
        cyc(0, rb(), ro(), 1, fetch_row(0));
      end
    endcase
  endtask

  task automatic bcheck(input logic [16:0] e, input string name);
    checks++;
    if (b_act !== e) begin
      errors++;
      $display("FAIL %s got=%05h expected=%05h", name, b_act, e);
    end
  endtask

  initial begin
    b_reset = 1'b1;
    b_op    = 7'h63;
    b_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 b_reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      repeat (5) begin
        @(negedge clk);
        bcheck(fetch_row(0), "nobr_fetch_stall");
        @(posedge clk);
        #1;
      end
      b_ready = 1'b1;
      @(negedge clk);
      bcheck(fetch_row(1), "nobr_fetch_ready");
      @(posedge clk);
      #1 b_ready = 1'b0;
      @(negedge clk);
      bcheck(decode_row(), "nobr_decode");
      repeat (3) begin
        @(posedge clk);
        #1 b_ready = 1'b1;
        @(negedge clk);
        bcheck(trap_row(), k == 0 ? "nobr_branch_trap" : "nojal_trap");
      end
      @(posedge clk);
      #1 b_reset = 1'b1;
      b_ready = 1'b0;
      b_op    = 7'h6F;
      @(posedge clk);
      #1 b_reset = 1'b0;
    end
    b_done = 1'b1;
  end

  initial begin
    logic [6:0] op;
    int         k;
    logic [6:0] legal_ops [7];
    legal_ops = '{7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h63, 7'h6F};
    reset = 1'b1;
    Mem_Ready_i = 1'b0;
    Zero_i = 1'b0;
    OP_i = 7'h00;
    cyc(0, 0, 7'h00, 1, fetch_row(0));
    cyc(0, 1, 7'h23, 1, fetch_row(0));
    issue(7'h23, 0, 0, 2, 1, 0);
    issue(7'h33, 0, 0, 0, 0, 0);
    issue(7'h03, 0, 0, 3, 0, 0);
    issue(7'h23, 0, 1, 0, 0, 0);
    issue(7'h63, 1, 0, 0, 0, 0);
    issue(7'h63, 0, 0, 0, 0, 0);
    issue(7'h6F, 0, 2, 0, 0, 0);
    issue(7'h7F, 0, 0, 0, 0, 22);
    issue(7'h37, 0, 0, 0, 0, 0);
    issue(7'h13, 0, 0, 0, 0, 0);
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 9);
      if (k < 7) begin
        op = legal_ops[k];
      end else begin
        op = ro();
        while (is_legal(op)) op = ro();
      end
      issue(op, rb(), $urandom_range(0, 3), $urandom_range(0, 3),
            ($urandom_range(0, 5) == 0), $urandom_range(2, 6));
    end
    cyc(0, 0, 7'h00, 0, fetch_row(0));
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d expected=0", exp_q.size());
    end
    for (int t = 0; t < 1000 && !b_done; t++) @(posedge clk);
    if (!b_done) begin
      errors++;
      checks++;
      $display("FAIL nobr_timeout got=0 expected=1");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
